// File: rtl/sw_debounce_ctrl.sv
`timescale 1ns/1ps
// Purpose: debounce a bouncy switch pin into a clean level, rise/fall strobes, a press toggle and a long-press strobe.
// Latency: Sw_clean follows a steady Sw_raw change after DEBOUNCE_CYCLES+3 edges; all outputs are registered.
// Backpressure: none; a free-running sampled input with no handshake, every cycle is consumed.
//
// Ports:
//   Clk_50M   - system clock, all logic on its rising edge
//   Rst_n     - asynchronous active-low reset
//   Sw_raw    - asynchronous, bouncy switch input
//   Sw_clean  - debounced level
//   Sw_rise   - one-cycle strobe when Sw_clean goes 0->1
//   Sw_fall   - one-cycle strobe when Sw_clean goes 1->0
//   Sw_toggle - flips on every accepted press
//   Sw_long   - one-cycle strobe once a press has been held LONG_CYCLES
module sw_debounce_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int LONG_CYCLES     = 100000000,
  parameter int LCNT_W          = 27
) (
  input  logic Clk_50M,
  input  logic Rst_n,
  input  logic Sw_raw,
  output logic Sw_clean,
  output logic Sw_rise,
  output logic Sw_fall,
  output logic Sw_toggle,
  output logic Sw_long
);

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_CHK_HIGH = 2'd1,
    ST_HIGH     = 2'd2,
    ST_CHK_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LCNT_W-1:0] HCNT_MAX = LCNT_W'(LONG_CYCLES - 1);

  state_t              state, state_nxt;
  logic                sync1, sync2;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [LCNT_W-1:0]   hcnt, hcnt_nxt;
  logic                long_done, long_done_nxt;
  logic                clean_nxt, rise_nxt, fall_nxt, toggle_nxt, long_nxt;

  // Two-flop synchronizer; only sync2 is allowed to reach the FSM.
  always_ff @(posedge Clk_50M or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= Sw_raw;
      sync2 <= sync1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge Clk_50M or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= ST_LOW;
      cnt       <= '0;
      hcnt      <= '0;
      long_done <= 1'b0;
      Sw_clean  <= 1'b0;
      Sw_rise   <= 1'b0;
      Sw_fall   <= 1'b0;
      Sw_toggle <= 1'b0;
      Sw_long   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hcnt      <= hcnt_nxt;
      long_done <= long_done_nxt;
      Sw_clean  <= clean_nxt;
      Sw_rise   <= rise_nxt;
      Sw_fall   <= fall_nxt;
      Sw_toggle <= toggle_nxt;
      Sw_long   <= long_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    hcnt_nxt      = hcnt;
    long_done_nxt = long_done;
    clean_nxt     = Sw_clean;
    toggle_nxt    = Sw_toggle;
    rise_nxt      = 1'b0;
    fall_nxt      = 1'b0;
    long_nxt      = 1'b0;

    case (state)
      ST_LOW: begin
        if (sync2) begin
          state_nxt = ST_CHK_HIGH;
          cnt_nxt   = '0;
        end
      end
      ST_CHK_HIGH: begin
        // Any low sample is treated as bounce: fall back silently.
        if (!sync2) begin
          state_nxt = ST_LOW;
        end else if (cnt == CNT_MAX) begin
          state_nxt  = ST_HIGH;
          clean_nxt  = 1'b1;
          rise_nxt   = 1'b1;
          toggle_nxt = ~Sw_toggle;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!sync2) begin
          state_nxt = ST_CHK_LOW;
          cnt_nxt   = '0;
        end
      end
      ST_CHK_LOW: begin
        if (sync2) begin
          state_nxt = ST_HIGH;
        end else if (cnt == CNT_MAX) begin
          state_nxt = ST_LOW;
          clean_nxt = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_LOW;
      end
    endcase

    // Hold counter keeps running while a release is being qualified, since
    // the button is still physically down. Leaving for LOW clears it, which
    // also keeps Sw_long from ever landing on the same cycle as Sw_fall.
    if (state_nxt == ST_LOW) begin
      hcnt_nxt      = '0;
      long_done_nxt = 1'b0;
    end else if (state == ST_HIGH || state == ST_CHK_LOW) begin
      if (hcnt == HCNT_MAX) begin
        // Saturated: fire once, then stay quiet until the next press.
        if (!long_done) begin
          long_nxt      = 1'b1;
          long_done_nxt = 1'b1;
        end
      end else begin
        hcnt_nxt = hcnt + LCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sw_debounce_ctrl.sv
`timescale 1ns/1ps
module tb_sw_debounce_ctrl;

  localparam int DEB = 4;
  localparam int LNG = 10;

  logic Clk_50M = 1'b0;
  logic Rst_n   = 1'b0;
  logic Sw_raw  = 1'b0;
  logic Sw_clean, Sw_rise, Sw_fall, Sw_toggle, Sw_long;
  logic [4:0] outs;

  int n_cmp = 0;
  int n_err = 0;
  int rise_cnt = 0, fall_cnt = 0, long_cnt = 0, clean_cnt = 0;
  int r0, f0, l0, c0;
  int pat [8] = '{1, 1, 0, 1, 1, 1, 1, 1};

  assign outs = {Sw_clean, Sw_rise, Sw_fall, Sw_toggle, Sw_long};

  always #10 Clk_50M = ~Clk_50M;

  sw_debounce_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3),
    .LONG_CYCLES    (LNG),
    .LCNT_W         (4)
  ) dut (
    .Clk_50M  (Clk_50M),
    .Rst_n    (Rst_n),
    .Sw_raw   (Sw_raw),
    .Sw_clean (Sw_clean),
    .Sw_rise  (Sw_rise),
    .Sw_fall  (Sw_fall),
    .Sw_toggle(Sw_toggle),
    .Sw_long  (Sw_long)
  );

  // Strobe/level counters sampled mid-cycle, one count per high cycle.
  always @(negedge Clk_50M) begin
    if (Sw_rise)  rise_cnt++;
    if (Sw_fall)  fall_cnt++;
    if (Sw_long)  long_cnt++;
    if (Sw_clean) clean_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk_50M);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    Sw_raw = 1'b0;
    Rst_n  = 1'b0;
    tick(3);
    chk("reset_outs", int'(outs), 0);
    Rst_n = 1'b1;
    tick(2);

    // 1: clean press, edge 1 is the first edge after Sw_raw rises
    r0 = rise_cnt; f0 = fall_cnt; l0 = long_cnt;
    Sw_raw = 1'b1;
    tick(6);
    chk("t1_clean_e6", int'(Sw_clean), 0);
    chk("t1_rise_e6", int'(Sw_rise), 0);
    tick(1);
    chk("t1_clean_e7", int'(Sw_clean), 1);
    chk("t1_rise_e7", int'(Sw_rise), 1);
    chk("t1_toggle_e7", int'(Sw_toggle), 1);
    tick(1);
    chk("t1_rise_e8", int'(Sw_rise), 0);
    chk("t1_fall_cnt_press", fall_cnt - f0, 0);
    Sw_raw = 1'b0;
    tick(6);
    chk("t1_clean_rel_e6", int'(Sw_clean), 1);
    chk("t1_fall_rel_e6", int'(Sw_fall), 0);
    tick(1);
    chk("t1_clean_rel_e7", int'(Sw_clean), 0);
    chk("t1_fall_rel_e7", int'(Sw_fall), 1);
    chk("t1_toggle_rel", int'(Sw_toggle), 1);
    tick(2);
    chk("t1_rise_cnt", rise_cnt - r0, 1);
    chk("t1_fall_cnt", fall_cnt - f0, 1);
    chk("t1_long_cnt", long_cnt - l0, 0);

    // 2: bounce 1,1,0,1,1,1,1,1 -> accepted 7 edges after the last 0 (edge 10)
    r0 = rise_cnt;
    for (int i = 0; i < 8; i++) begin
      Sw_raw = pat[i][0];
      tick(1);
    end
    chk("t2_clean_e8", int'(Sw_clean), 0);
    tick(1);
    chk("t2_clean_e9", int'(Sw_clean), 0);
    tick(1);
    chk("t2_clean_e10", int'(Sw_clean), 1);
    chk("t2_rise_e10", int'(Sw_rise), 1);
    chk("t2_toggle", int'(Sw_toggle), 0);
    Sw_raw = 1'b0;
    tick(7);
    chk("t2_clean_rel", int'(Sw_clean), 0);
    tick(2);
    chk("t2_rise_cnt", rise_cnt - r0, 1);

    // 3: 3-cycle glitch is rejected
    r0 = rise_cnt; f0 = fall_cnt; c0 = clean_cnt;
    Sw_raw = 1'b1;
    tick(3);
    Sw_raw = 1'b0;
    tick(12);
    chk("t3_clean", int'(Sw_clean), 0);
    chk("t3_clean_cnt", clean_cnt - c0, 0);
    chk("t3_rise_cnt", rise_cnt - r0, 0);
    chk("t3_fall_cnt", fall_cnt - f0, 0);
    chk("t3_toggle", int'(Sw_toggle), 0);

    // 4: long press, HIGH entry at edge 7, Sw_long after edge 17
    l0 = long_cnt;
    Sw_raw = 1'b1;
    tick(7);
    chk("t4_rise", int'(Sw_rise), 1);
    chk("t4_toggle", int'(Sw_toggle), 1);
    tick(9);
    chk("t4_long_e16", int'(Sw_long), 0);
    tick(1);
    chk("t4_long_e17", int'(Sw_long), 1);
    tick(1);
    chk("t4_long_e18", int'(Sw_long), 0);
    tick(19);
    chk("t4_long_cnt_held", long_cnt - l0, 1);
    Sw_raw = 1'b0;
    tick(6);
    chk("t4_fall_e6", int'(Sw_fall), 0);
    tick(1);
    chk("t4_fall_e7", int'(Sw_fall), 1);
    chk("t4_clean_rel", int'(Sw_clean), 0);
    chk("t4_toggle_rel", int'(Sw_toggle), 1);
    tick(2);
    chk("t4_long_cnt", long_cnt - l0, 1);

    // 5: fresh reset, then two presses -> toggle 0,1,0
    Rst_n = 1'b0;
    tick(1);
    Rst_n = 1'b1;
    tick(2);
    chk("t5_toggle_start", int'(Sw_toggle), 0);
    r0 = rise_cnt; f0 = fall_cnt;
    for (int p = 0; p < 2; p++) begin
      Sw_raw = 1'b1;
      tick(7);
      chk("t5_clean_press", int'(Sw_clean), 1);
      chk("t5_toggle_press", int'(Sw_toggle), (p == 0) ? 1 : 0);
      Sw_raw = 1'b0;
      tick(7);
      chk("t5_fall_rel", int'(Sw_fall), 1);
      chk("t5_clean_rel", int'(Sw_clean), 0);
    end
    tick(2);
    chk("t5_rise_cnt", rise_cnt - r0, 2);
    chk("t5_fall_cnt", fall_cnt - f0, 2);

    // 6: asynchronous reset mid-qualification and mid-hold
    Sw_raw = 1'b1;
    tick(7);
    Sw_raw = 1'b0;
    tick(9);
    chk("t6_toggle_pre", int'(Sw_toggle), 1);
    Sw_raw = 1'b1;
    tick(5);                       // CHK_HIGH with cnt=2
    Rst_n = 1'b0;
    #2;
    chk("t6_rst_chk_high", int'(outs), 0);
    #2;
    Rst_n = 1'b1;
    tick(6);
    chk("t6_clean_e6", int'(Sw_clean), 0);
    tick(1);
    chk("t6_rise_e7", int'(Sw_rise), 1);
    chk("t6_toggle_e7", int'(Sw_toggle), 1);
    tick(5);                       // HIGH with hcnt=5
    chk("t6_clean_high", int'(Sw_clean), 1);
    Rst_n = 1'b0;
    #2;
    chk("t6_rst_high", int'(outs), 0);
    #2;
    Rst_n = 1'b1;
    tick(6);
    chk("t6b_clean_e6", int'(Sw_clean), 0);
    tick(1);
    chk("t6b_rise_e7", int'(Sw_rise), 1);
    chk("t6b_toggle_e7", int'(Sw_toggle), 1);
    chk("t6b_clean_e7", int'(Sw_clean), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
